// File: rtl/race_input_pkg.sv
// Shared key codes and start-FSM state type for the race input encoder slice.
package race_input_pkg;

  localparam logic [7:0] KEY_NONE  = 8'h00;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_ENTER = 8'h28;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PULSE,
    ST_HELD
  } start_state_t;

  function automatic logic is_drive_key(input logic [7:0] code);
    return (code == KEY_W) || (code == KEY_A) || (code == KEY_S) || (code == KEY_D);
  endfunction

endpackage

// File: rtl/hid_slot_decode.sv
// Combinational decode of a six-slot HID report into the first drive key
// (slot0 has priority) and an any-slot Enter flag.
module hid_slot_decode
  import race_input_pkg::*;
(
  input  logic [47:0] keys,
  output logic [7:0]  drv,
  output logic        ent
);

  // Scan from slot5 down so the lowest-numbered drive slot is the one that sticks.
  always_comb begin
    drv = KEY_NONE;
    ent = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      if (is_drive_key(keys[i*8 +: 8])) begin
        drv = keys[i*8 +: 8];
      end
      if (keys[i*8 +: 8] == KEY_ENTER) begin
        ent = 1'b1;
      end
    end
  end

endmodule

// File: rtl/race_input_encoder.sv
// HID report -> debounced drive key (keycode_0) and start pulse (keycode_1) with stale-link guard.
// Optional Enter auto-repeat is built when KEYCODE_REPEAT_EN is defined.
module race_input_encoder
  import race_input_pkg::*;
#(
  parameter int TIMEOUT_FRAMES  = 30,
  parameter int REPEAT_FRAMES   = 45,
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic        hid_valid,
  output logic        hid_ready,
  input  logic [47:0] hid_keys,
  output logic [7:0]  keycode_0,
  output logic [7:0]  keycode_1,
  output logic        stale
);

  localparam int TMO_W = $clog2(TIMEOUT_FRAMES + 1);
  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_FRAMES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_FRAMES);

  logic             accept;
  logic [7:0]       drv;
  logic             ent;
  logic [TMO_W-1:0] tmo;
  logic [TMO_W-1:0] tmo_inc;
  logic             go_stale;
  logic [7:0]       cand;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             ent_last;
  logic             ent_eval;
  start_state_t     state;

`ifdef KEYCODE_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_FRAMES + 1);
  localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_FRAMES);
  logic [RPT_W-1:0] rpt;
  logic [RPT_W-1:0] rpt_inc;
  assign rpt_inc = (rpt == RPT_MAX) ? rpt : rpt + 1'b1;
`endif

  hid_slot_decode u_decode (
    .keys (hid_keys),
    .drv  (drv),
    .ent  (ent)
  );

  assign accept   = hid_valid & hid_ready;
  assign tmo_inc  = (tmo == TMO_MAX) ? tmo : tmo + 1'b1;
  // Asserted on every idle edge that leaves (or keeps) the timeout saturated.
  assign go_stale = !accept && (tmo_inc == TMO_MAX);
  assign ent_eval = accept ? ent : ent_last;

  always_comb begin
    cnt_next = '0;
    if (drv == KEY_NONE) begin
      cnt_next = '0;
    end else if (drv == cand) begin
      cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    end else begin
      cnt_next = CNT_W'(1);
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      hid_ready <= 1'b0;
      tmo       <= '0;
      stale     <= 1'b0;
    end else begin
      hid_ready <= 1'b1;
      if (accept) begin
        tmo   <= '0;
        stale <= 1'b0;
      end else begin
        tmo   <= tmo_inc;
        stale <= (tmo_inc == TMO_MAX);
      end
    end
  end

  // Drive debounce: the old key keeps showing until the new one has been seen enough times.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      cand      <= KEY_NONE;
      cnt       <= '0;
      keycode_0 <= KEY_NONE;
    end else if (accept) begin
      cand <= drv;
      cnt  <= cnt_next;
      if (drv == KEY_NONE) begin
        keycode_0 <= KEY_NONE;
      end else if (cnt_next == CNT_MAX) begin
        keycode_0 <= drv;
      end
    end else if (go_stale) begin
      cand      <= KEY_NONE;
      cnt       <= '0;
      keycode_0 <= KEY_NONE;
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      keycode_1 <= KEY_NONE;
      ent_last  <= 1'b0;
`ifdef KEYCODE_REPEAT_EN
      rpt       <= '0;
`endif
    end else begin
      if (accept) begin
        ent_last <= ent;
      end
      if (go_stale) begin
        state     <= ST_IDLE;
        keycode_1 <= KEY_NONE;
        ent_last  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            keycode_1 <= KEY_NONE;
            if (accept && ent) begin
              state     <= ST_PULSE;
              keycode_1 <= KEY_ENTER;
            end
          end
          // Pulse lasts one frame whether or not a report arrives; fall back on the last one.
          ST_PULSE: begin
            keycode_1 <= KEY_NONE;
            if (ent_eval) begin
              state <= ST_HELD;
`ifdef KEYCODE_REPEAT_EN
              rpt   <= '0;
`endif
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_HELD: begin
            keycode_1 <= KEY_NONE;
            if (accept && !ent) begin
              state <= ST_IDLE;
            end
`ifdef KEYCODE_REPEAT_EN
            else if (rpt_inc == RPT_MAX) begin
              state     <= ST_PULSE;
              keycode_1 <= KEY_ENTER;
            end else begin
              rpt <= rpt_inc;
            end
`endif
          end
          default: begin
            state     <= ST_IDLE;
            keycode_1 <= KEY_NONE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_race_input_encoder.sv
// Self-checking bench for race_input_encoder: vector table with an expected-value
// queue plus hand sequences for reset, timeout and Enter hold/repeat (KEYCODE_REPEAT_EN aware).
module tb_race_input_encoder;

  logic        frame_clk;
  logic        Reset;
  logic        hid_valid;
  logic        hid_ready;
  logic [47:0] hid_keys;
  logic [7:0]  keycode_0;
  logic [7:0]  keycode_1;
  logic        stale;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        valid;
    logic [47:0] keys;
    logic [7:0]  kc0;
    logic [7:0]  kc1;
    logic        stale;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[$];

  race_input_encoder dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .hid_valid (hid_valid),
    .hid_ready (hid_ready),
    .hid_keys  (hid_keys),
    .keycode_0 (keycode_0),
    .keycode_1 (keycode_1),
    .stale     (stale)
  );

  initial frame_clk = 1'b0;
  always #5 frame_clk = ~frame_clk;

  function automatic vec_t mk(input logic v, input logic [47:0] k, input logic [7:0] kc0,
                              input logic [7:0] kc1, input logic st);
    vec_t r;
    r.valid = v;
    r.keys  = k;
    r.kc0   = kc0;
    r.kc1   = kc1;
    r.stale = st;
    return r;
  endfunction

  function automatic logic [47:0] one(input logic [7:0] k);
    return {40'h0, k};
  endfunction

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  // Drives one frame of input, queues its expected result and advances past the edge.
  task automatic apply_stimulus(input vec_t v);
    hid_valid = v.valid;
    hid_keys  = v.keys;
    exp_q.push_back(v);
    @(posedge frame_clk);
    #1;
  endtask

  task automatic check_output(input string name);
    vec_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: scoreboard empty, got nothing, want one entry", name);
    end else begin
      e = exp_q.pop_front();
      cmp({name, ".ready"}, {7'b0, hid_ready}, 8'h01);
      cmp({name, ".kc0"}, keycode_0, e.kc0);
      cmp({name, ".kc1"}, keycode_1, e.kc1);
      cmp({name, ".stale"}, {7'b0, stale}, {7'b0, e.stale});
    end
  endtask

  task automatic run(input vec_t v, input string name);
    apply_stimulus(v);
    check_output(name);
  endtask

  initial begin
    logic [47:0] prio;
    logic        exp_pulse;
    prio = {8'h00, 8'h28, 8'h28, 8'h1A, 8'h04, 8'h00};

    Reset     = 1'b1;
    hid_valid = 1'b0;
    hid_keys  = '0;
    #3;
    cmp("rst.ready", {7'b0, hid_ready}, 8'h00);
    cmp("rst.kc0", keycode_0, 8'h00);
    cmp("rst.kc1", keycode_1, 8'h00);
    cmp("rst.stale", {7'b0, stale}, 8'h00);
    @(posedge frame_clk);
    #3;
    Reset = 1'b0;
    cmp("rel.ready_before_edge", {7'b0, hid_ready}, 8'h00);
    @(posedge frame_clk);
    #1;
    cmp("rel.ready_after_edge", {7'b0, hid_ready}, 8'h01);

    // T1: reset in the middle of a start pulse
    run(mk(1'b1, one(8'h28), 8'h00, 8'h28, 1'b0), "t1.press");
    #2;
    Reset = 1'b1;
    #1;
    cmp("t1.mid.ready", {7'b0, hid_ready}, 8'h00);
    cmp("t1.mid.kc1", keycode_1, 8'h00);
    cmp("t1.mid.kc0", keycode_0, 8'h00);
    cmp("t1.mid.stale", {7'b0, stale}, 8'h00);
    hid_valid = 1'b0;
    hid_keys  = '0;
    @(posedge frame_clk);
    #3;
    Reset = 1'b0;
    @(posedge frame_clk);
    #1;
    cmp("t1.rel.ready", {7'b0, hid_ready}, 8'h01);
    run(mk(1'b1, 48'h0, 8'h00, 8'h00, 1'b0), "t1.no_owed_pulse");

    // T2 debounce, T3 start pulse, T4 priority
    tbl.push_back(mk(1'b1, one(8'h1A), 8'h00, 8'h00, 1'b0));
    tbl.push_back(mk(1'b1, one(8'h1A), 8'h1A, 8'h00, 1'b0));
    tbl.push_back(mk(1'b1, one(8'h07), 8'h1A, 8'h00, 1'b0));
    tbl.push_back(mk(1'b1, one(8'h07), 8'h07, 8'h00, 1'b0));
    tbl.push_back(mk(1'b1, 48'h0,      8'h00, 8'h00, 1'b0));
    tbl.push_back(mk(1'b1, one(8'h28), 8'h00, 8'h28, 1'b0));
    for (int i = 0; i < 9; i++) tbl.push_back(mk(1'b1, one(8'h28), 8'h00, 8'h00, 1'b0));
    tbl.push_back(mk(1'b1, 48'h0,      8'h00, 8'h00, 1'b0));
    tbl.push_back(mk(1'b1, one(8'h28), 8'h00, 8'h28, 1'b0));
    tbl.push_back(mk(1'b1, 48'h0,      8'h00, 8'h00, 1'b0));
    tbl.push_back(mk(1'b1, prio,       8'h00, 8'h28, 1'b0));
    tbl.push_back(mk(1'b1, prio,       8'h04, 8'h00, 1'b0));
    tbl.push_back(mk(1'b1, 48'h0,      8'h00, 8'h00, 1'b0));
    for (int i = 0; i < tbl.size(); i++) begin
      run(tbl[i], $sformatf("vec%0d", i));
    end

    // T5: link goes quiet while S is held
    run(mk(1'b1, one(8'h16), 8'h00, 8'h00, 1'b0), "t5.s1");
    run(mk(1'b1, one(8'h16), 8'h16, 8'h00, 1'b0), "t5.s2");
    for (int i = 1; i <= 32; i++) begin
      run(mk(1'b0, one(8'h16), (i < 30) ? 8'h16 : 8'h00, 8'h00, (i >= 30)),
          $sformatf("t5.idle%0d", i));
    end
    run(mk(1'b1, one(8'h28), 8'h00, 8'h28, 1'b0), "t5.fresh_pulse");
    run(mk(1'b1, 48'h0,      8'h00, 8'h00, 1'b0), "t5.release");

    // T6: Enter held for 100 frames
    for (int f = 1; f <= 100; f++) begin
`ifdef KEYCODE_REPEAT_EN
      exp_pulse = ((f - 1) % 46) == 0;
`else
      exp_pulse = (f == 1);
`endif
      run(mk(1'b1, one(8'h28), 8'h00, exp_pulse ? 8'h28 : 8'h00, 1'b0),
          $sformatf("t6.frame%0d", f));
    end
    run(mk(1'b1, 48'h0, 8'h00, 8'h00, 1'b0), "t6.release");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
